// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester streams and TX FIFO write port shared by the UART TX arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_wdata;
  logic                 tx_wten;
  logic                 tx_fifo_full;

  modport master (
    output req_valid, req_data, req_last, tx_fifo_full,
    input  req_ready, tx_wdata, tx_wten
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_fifo_full,
    output req_ready, tx_wdata, tx_wten
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-granular arbiter onto the UART TX FIFO write port
// Optional UART_TX_CRLF_EN: expand an owner's 0x0A into 0x0D 0x0A.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_tx_arbiter_if.slave  bus,
  output logic [1:0]        o_grant_id,
  output logic              o_busy,
  output logic              o_timeout_err
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_OWN    = 2'd1;
`ifdef UART_TX_CRLF_EN
  localparam logic [1:0]  ST_CRLF   = 2'd2;
`endif
  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);
  localparam logic [1:0]  LAST_INIT = 2'(NUM_REQ - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_grant;
  logic [1:0]  r_last_owner;
  logic        r_busy;
  logic [15:0] r_timer;

  logic        w_owner_valid;
  logic        w_owner_last;
  logic [7:0]  w_owner_data;
  logic        w_pick_found;
  logic [1:0]  w_pick;
  logic        w_timeout;
  logic        w_ready_g;
  logic        w_xfer;
  logic        w_cr;

  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_last  = 1'b0;
    w_owner_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == 2'(i)) begin
        w_owner_valid = bus.req_valid[i];
        w_owner_last  = bus.req_last[i];
        w_owner_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  // Scan starts one past the previous owner so every waiting port is reached within NUM_REQ grants.
  always_comb begin
    int idx;
    idx          = 0;
    w_pick_found = 1'b0;
    w_pick       = r_last_owner;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last_owner) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_pick_found && idx == i && bus.req_valid[i]) begin
          w_pick_found = 1'b1;
          w_pick       = 2'(i);
        end
      end
    end
  end

  assign w_timeout = (r_state != ST_IDLE) && (r_timer == TIMEOUT_V);

  always_comb begin
    w_ready_g     = 1'b0;
    w_xfer        = 1'b0;
    w_cr          = 1'b0;
    o_timeout_err = 1'b0;
    bus.tx_wten   = 1'b0;
    bus.tx_wdata  = 8'h00;
    bus.req_ready = '0;
    if (!i_rst) begin
      case (r_state)
        ST_OWN: begin
          if (w_timeout) begin
            o_timeout_err = 1'b1;
          end else begin
`ifdef UART_TX_CRLF_EN
            if (w_owner_valid && w_owner_data == 8'h0A) begin
              w_cr = ~bus.tx_fifo_full;
            end else begin
              w_ready_g = ~bus.tx_fifo_full;
            end
`else
            w_ready_g = ~bus.tx_fifo_full;
`endif
          end
        end
`ifdef UART_TX_CRLF_EN
        ST_CRLF: begin
          if (w_timeout) begin
            o_timeout_err = 1'b1;
          end else begin
            w_ready_g = ~bus.tx_fifo_full;
          end
        end
`endif
        default: ;
      endcase
      w_xfer      = w_ready_g & w_owner_valid;
      bus.tx_wten = w_xfer | w_cr;
      if (w_cr) begin
        bus.tx_wdata = 8'h0D;
      end else if (w_xfer) begin
        bus.tx_wdata = w_owner_data;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_ready[i] = w_ready_g && (r_grant == 2'(i));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'd0;
      r_last_owner <= LAST_INIT;
      r_busy       <= 1'b0;
      r_timer      <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_timer <= 16'd0;
            r_state <= ST_OWN;
          end
        end
        default: begin
          if (w_timeout) begin
            r_state      <= ST_IDLE;
            r_last_owner <= r_grant;
            r_busy       <= 1'b0;
            r_timer      <= 16'd0;
          end else if (w_xfer || w_cr) begin
            r_timer <= 16'd0;
`ifdef UART_TX_CRLF_EN
            if (w_cr) begin
              r_state <= ST_CRLF;
            end else
`endif
            if (w_owner_last) begin
              r_state      <= ST_IDLE;
              r_last_owner <= r_grant;
              r_busy       <= 1'b0;
            end else begin
              r_state <= ST_OWN;
            end
          end else if (!w_owner_valid && !bus.tx_fifo_full) begin
            // Only an idle owner with room in the FIFO counts as a stall.
            r_timer <= r_timer + 16'd1;
          end
        end
      endcase
    end
  end

  assign o_grant_id = r_grant;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 3;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .o_grant_id    (grant_id),
    .o_busy        (busy),
    .o_timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]  pq0[$];
  logic [8:0]  pq1[$];
  logic [8:0]  pq2[$];
  logic [10:0] exp_q[$];
  logic [NUM_REQ-1:0] hold = '0;
  logic [NUM_REQ-1:0] acc  = '0;
  logic prev_last = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int size_of(input int p);
    case (p)
      0:       return pq0.size();
      1:       return pq1.size();
      default: return pq2.size();
    endcase
  endfunction

  function automatic logic [8:0] head_of(input int p);
    if (size_of(p) == 0) return 9'h000;
    case (p)
      0:       return pq0[0];
      1:       return pq1[0];
      default: return pq2[0];
    endcase
  endfunction

  task automatic push_req(input int p, input logic [7:0] d, input logic l);
    case (p)
      0:       pq0.push_back({l, d});
      1:       pq1.push_back({l, d});
      default: pq2.push_back({l, d});
    endcase
  endtask

  task automatic push_exp(input int p, input logic [7:0] d, input logic l);
    exp_q.push_back({l, 2'(p), d});
  endtask

  // Requester driver: retire accepted heads, then present the next byte of each port.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (acc[0] && pq0.size() > 0) void'(pq0.pop_front());
      if (acc[1] && pq1.size() > 0) void'(pq1.pop_front());
      if (acc[2] && pq2.size() > 0) void'(pq2.pop_front());
      for (int p = 0; p < NUM_REQ; p++) begin
        bus.req_valid[p]        = !hold[p] && (size_of(p) > 0);
        bus.req_data[8*p +: 8]  = head_of(p)[7:0];
        bus.req_last[p]         = head_of(p)[8];
      end
    end
  end

  // Monitor: every FIFO write is matched against the scoreboard.
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst) begin
      acc       = '0;
      prev_last = 1'b0;
    end else begin
      acc = bus.req_valid & bus.req_ready;
      if (prev_last) chk("bubble_after_last", 32'(bus.tx_wten), 32'd0);
      prev_last = 1'b0;
      if (bus.tx_wten) begin
        chk("wten_while_full", 32'(bus.tx_fifo_full), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got %02h, expected no write at %0t", bus.tx_wdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("tx_wdata", 32'(bus.tx_wdata), 32'(e[7:0]));
          chk("grant_id_on_write", 32'(grant_id), 32'(e[9:8]));
          prev_last = e[10];
        end
      end
    end
  end

  task automatic wait_write(input logic [7:0] d);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.tx_wten && bus.tx_wdata == d) && k < 300);
    chk($sformatf("seen_write_%02h", d), 32'(bus.tx_wten && bus.tx_wdata == d), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(pq0.size() == 0 && pq1.size() == 0 && pq2.size() == 0 &&
                 exp_q.size() == 0 && !busy) && k < 500);
    chk(name, 32'(pq0.size() + pq1.size() + pq2.size() + exp_q.size() + int'(busy)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    bus.tx_fifo_full = 1'b0;

    // Reset with every requester valid, then port 0 wins first.
    push_req(0, 8'h10, 1'b1); push_req(1, 8'h11, 1'b1); push_req(2, 8'h12, 1'b1);
    push_exp(0, 8'h10, 1'b1); push_exp(1, 8'h11, 1'b1); push_exp(2, 8'h12, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_valid_all", 32'(bus.req_valid), 32'h7);
    chk("rst_tx_wten", 32'(bus.tx_wten), 32'd0);
    chk("rst_tx_wdata", 32'(bus.tx_wdata), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("arb_bubble_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("first_grant_busy", 32'(busy), 32'd1);
    chk("first_grant_id", 32'(grant_id), 32'd0);
    chk("first_grant_write", 32'(bus.tx_wten), 32'd1);
    wait_idle("t1_drain");

    // Port 1 sends "AB".
    push_req(1, 8'h41, 1'b0); push_req(1, 8'h42, 1'b1);
    push_exp(1, 8'h41, 1'b0); push_exp(1, 8'h42, 1'b1);
    wait_write(8'h41);
    @(negedge clk);
    chk("t2_consecutive_B", 32'(bus.tx_wten && bus.tx_wdata == 8'h42), 32'd1);
    @(negedge clk);
    chk("t2_busy_falls", 32'(busy), 32'd0);
    wait_idle("t2_drain");

    // Fresh reset so last_owner points at port 2, then three competing messages.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push_req(0, 8'h30, 1'b0); push_req(0, 8'h31, 1'b1);
    push_req(1, 8'h32, 1'b0); push_req(1, 8'h33, 1'b1);
    push_req(2, 8'h34, 1'b0); push_req(2, 8'h35, 1'b1);
    push_exp(0, 8'h30, 1'b0); push_exp(0, 8'h31, 1'b1);
    push_exp(1, 8'h32, 1'b0); push_exp(1, 8'h33, 1'b1);
    push_exp(2, 8'h34, 1'b0); push_exp(2, 8'h35, 1'b1);
    wait_idle("t3_drain");

    // FIFO full for 10 cycles mid-message.
    push_req(0, 8'h71, 1'b0); push_req(0, 8'h72, 1'b0); push_req(0, 8'h73, 1'b1);
    push_exp(0, 8'h71, 1'b0); push_exp(0, 8'h72, 1'b0); push_exp(0, 8'h73, 1'b1);
    wait_write(8'h71);
    @(posedge clk); #1 bus.tx_fifo_full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t4_full_ready", 32'(bus.req_ready), 32'd0);
      chk("t4_full_wten", 32'(bus.tx_wten), 32'd0);
      chk("t4_full_no_timeout", 32'(timeout_err), 32'd0);
      chk("t4_full_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1 bus.tx_fifo_full = 1'b0;
    wait_idle("t4_drain");

    // Owner stalls after first byte: forced release after TIMEOUT stall cycles.
    push_req(1, 8'h51, 1'b0); push_req(1, 8'h52, 1'b1);
    push_req(2, 8'h61, 1'b1);
    push_exp(1, 8'h51, 1'b0); push_exp(2, 8'h61, 1'b1); push_exp(1, 8'h52, 1'b1);
    wait_write(8'h51);
    hold[1] = 1'b1;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      chk("t5_no_early_timeout", 32'(timeout_err), 32'd0);
    end
    @(negedge clk);
    chk("t5_timeout_pulse", 32'(timeout_err), 32'd1);
    chk("t5_timeout_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("t5_pulse_one_cycle", 32'(timeout_err), 32'd0);
    chk("t5_released", 32'(busy), 32'd0);
    wait_write(8'h61);
    hold[1] = 1'b0;
    wait_idle("t5_drain");

    // Line feed handling.
    push_req(0, 8'h58, 1'b0); push_req(0, 8'h0A, 1'b1);
    push_exp(0, 8'h58, 1'b0);
`ifdef UART_TX_CRLF_EN
    push_exp(0, 8'h0D, 1'b0);
`endif
    push_exp(0, 8'h0A, 1'b1);
    wait_idle("t6_drain");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
